// File: rtl/ula_seq.sv
// ula_seq: registered ULA with single-cycle ALU ops and optional iterative shift-add multiply
// Build option: define ULA_MUL_EN to compile in the MUL state and datapath (opcode 111).
// Ports:
//   Clock, Resetn       rising-edge clock, asynchronous active-low reset
//   Start, Operacao     launch request and operation select
//   A, Buswires         operands; Buswires[SHW-1:0] is the SHL amount
//   Ulaout              registered result, held until the next Done
//   Busy, Done          multicycle-in-progress, one-cycle result pulse
//   Zero/Neg/Carry/Ovf  status flags, updated only with Done
module ula_seq #(
    parameter int WIDTH = 16,
    localparam int SHW = $clog2(WIDTH)
) (
    input  logic             Clock,
    input  logic             Resetn,
    input  logic             Start,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] Buswires,
    input  logic [2:0]       Operacao,
    output logic [WIDTH-1:0] Ulaout,
    output logic             Busy,
    output logic             Done,
    output logic             Zero,
    output logic             Neg,
    output logic             Carry,
    output logic             Ovf
);
    logic [WIDTH:0] sum, dif, shl;
    logic [WIDTH-1:0] res, nres;
    logic cy, ov, nc, nv, cap;
    always_comb begin
        sum = {1'b0, A} + {1'b0, Buswires};
        dif = {1'b0, A} - {1'b0, Buswires};
        shl = {1'b0, A} << Buswires[SHW-1:0];
        res = '0;
        cy = 1'b0;
        ov = 1'b0;
        case (Operacao)
            3'b000: begin
                res = sum[WIDTH-1:0];
                cy = sum[WIDTH];
                ov = (A[WIDTH-1] == Buswires[WIDTH-1]) && (sum[WIDTH-1] != A[WIDTH-1]);
            end
            3'b001: begin
                res = dif[WIDTH-1:0];
                cy = dif[WIDTH];
                ov = (A[WIDTH-1] != Buswires[WIDTH-1]) && (dif[WIDTH-1] != A[WIDTH-1]);
            end
            3'b010: res = A & Buswires;
            3'b011: res = A | Buswires;
            3'b100: res = A ^ Buswires;
            3'b101: res = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(Buswires)};
            3'b110: begin
                res = shl[WIDTH-1:0];
                // bit WIDTH holds the last bit shifted out; a zero shift leaves it 0
                cy = shl[WIDTH];
            end
            default: res = '0;
        endcase
    end
`ifdef ULA_MUL_EN
    typedef enum logic {IDLE, MUL} state_t;
    state_t state, state_n;
    logic [2*WIDTH-1:0] mcand, acc, acc_n;
    logic [WIDTH-1:0] mplier;
    logic [SHW-1:0] cnt;
    assign acc_n = acc + (mplier[0] ? mcand : '0);
    assign Busy = (state == MUL);
    always_comb begin
        state_n = state;
        cap = 1'b0;
        nres = res;
        nc = cy;
        nv = ov;
        if (state == IDLE) begin
            if (Start && Operacao == 3'b111) state_n = MUL;
            else cap = Start;
        end else if (cnt == SHW'(WIDTH-1)) begin
            state_n = IDLE;
            cap = 1'b1;
            nres = acc_n[WIDTH-1:0];
            nc = |acc_n[2*WIDTH-1:WIDTH];
            nv = 1'b0;
        end
    end
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else state <= state_n;
    end
    // operands reload every idle cycle, so the values present on the Start edge are the ones kept
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            mcand <= '0;
            mplier <= '0;
            acc <= '0;
            cnt <= '0;
        end else if (state == IDLE) begin
            mcand <= {{WIDTH{1'b0}}, A};
            mplier <= Buswires;
            acc <= '0;
            cnt <= '0;
        end else begin
            mcand <= mcand << 1;
            mplier <= mplier >> 1;
            acc <= acc_n;
            cnt <= cnt + 1'b1;
        end
    end
`else
    assign Busy = 1'b0;
    assign cap = Start;
    assign nres = res;
    assign nc = cy;
    assign nv = ov;
`endif
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            Ulaout <= '0;
            Done <= 1'b0;
            Zero <= 1'b0;
            Neg <= 1'b0;
            Carry <= 1'b0;
            Ovf <= 1'b0;
        end else begin
            Done <= cap;
            if (cap) begin
                Ulaout <= nres;
                Zero <= (nres == '0);
                Neg <= nres[WIDTH-1];
                Carry <= nc;
                Ovf <= nv;
            end
        end
    end
endmodule
